// File: rtl/cirno9_sim_monitor_if.sv
// cirno9 run-monitor bus: core taps and run control in, counters and verdict out.
interface cirno9_sim_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32,
  parameter int N_EVT = 4
);
  logic                   start;
  logic                   clear;
  logic [XLEN-1:0]        pc;
  logic                   instr_retired;
  logic [N_EVT-1:0]       evt;
  logic [XLEN-1:0]        result;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       instret_cnt;
  logic [N_EVT*CNT_W-1:0] evt_cnt;
  logic [7:0]             hit_cnt;
  logic [1:0]             state;
  logic                   done;
  logic                   pass;
  logic                   fail;
  logic [XLEN-1:0]        result_q;

  modport master (
    output start, clear, pc, instr_retired, evt, result,
    input  cycle_cnt, instret_cnt, evt_cnt, hit_cnt,
    input  state, done, pass, fail, result_q
  );

  modport slave (
    input  start, clear, pc, instr_retired, evt, result,
    output cycle_cnt, instret_cnt, evt_cnt, hit_cnt,
    output state, done, pass, fail, result_q
  );
endinterface

// File: rtl/cirno9_sim_monitor.sv
// cirno9 run monitor: cycle/retire/event counters, tohost completion
// detection, pass/fail verdict and cycle timeout.
module cirno9_sim_monitor #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              N_EVT       = 4,
  parameter logic [XLEN-1:0] TOHOST_PC   = 'h8000003c,
  parameter int              HIT_LIMIT   = 3,
  parameter int              HIT_MODE    = 0,
  parameter logic [XLEN-1:0] PASS_VAL    = 'h1,
  parameter int unsigned     TIMEOUT_CYC = 2500
) (
  input logic                  clk,
  input logic                  rst,
  cirno9_sim_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } state_t;

  localparam logic [7:0]  HIT_LAST = 8'(HIT_LIMIT - 1);
  localparam bit          TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [63:0] TO_LAST  = 64'(TIMEOUT_CYC) - 64'd1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] inst_q;
  logic [CNT_W-1:0] evt_q [N_EVT];
  logic [7:0]       hit_q;
  logic             prev_q;
  logic [XLEN-1:0]  res_q;
  logic             pass_q;
  logic             fail_q;

  logic run;
  logic match;
  logic hit_now;
  logic complete;
  logic tmo;
  logic res_ok;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign run      = (state_q == RUN);
  assign match    = (bus.pc == TOHOST_PC);
  // Mode 1 only counts the first cycle of each visit to tohost.
  assign hit_now  = match && (HIT_MODE == 0 || !prev_q);
  assign complete = run && hit_now && (hit_q == HIT_LAST);
  // Widened compare so narrow counters never alias the budget.
  assign tmo      = run && TO_EN && (64'(cyc_q) == TO_LAST);
  assign res_ok   = (bus.result == PASS_VAL);

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = RUN;
        RUN: begin
          if (complete)  state_d = DONE;
          else if (tmo)  state_d = TMO;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      inst_q  <= '0;
      hit_q   <= '0;
      prev_q  <= 1'b0;
      res_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      for (int i = 0; i < N_EVT; i++) evt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (bus.clear) begin
        cyc_q  <= '0;
        inst_q <= '0;
        hit_q  <= '0;
        prev_q <= 1'b0;
        res_q  <= '0;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
        for (int i = 0; i < N_EVT; i++) evt_q[i] <= '0;
      end else if (state_q == IDLE) begin
        prev_q <= 1'b0;
      end else if (run) begin
        cyc_q  <= sat_inc(cyc_q, 1'b1);
        inst_q <= sat_inc(inst_q, bus.instr_retired);
        for (int i = 0; i < N_EVT; i++)
          evt_q[i] <= sat_inc(evt_q[i], bus.evt[i]);
        prev_q <= match;
        if (hit_now && hit_q != 8'hff)
          hit_q <= hit_q + 8'd1;
        // Completion beats a timeout landing on the same cycle.
        if (complete) begin
          res_q  <= bus.result;
          pass_q <= res_ok;
          fail_q <= !res_ok;
        end else if (tmo) begin
          res_q  <= bus.result;
          pass_q <= 1'b0;
          fail_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cycle_cnt   = cyc_q;
  assign bus.instret_cnt = inst_q;
  assign bus.hit_cnt     = hit_q;
  assign bus.state       = state_q;
  assign bus.done        = state_q[1];
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.result_q    = res_q;

  for (genvar g = 0; g < N_EVT; g++) begin : g_evt
    assign bus.evt_cnt[g*CNT_W +: CNT_W] = evt_q[g];
  end

endmodule

// File: tb/tb_cirno9_sim_monitor.sv
// Directed bench for cirno9_sim_monitor across four parameter sets.
module tb_cirno9_sim_monitor;

  localparam logic [31:0] M = 32'h8000003c;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cirno9_sim_monitor_if #(.XLEN(32), .CNT_W(32), .N_EVT(4)) ia ();
  cirno9_sim_monitor_if #(.XLEN(32), .CNT_W(32), .N_EVT(4)) ib ();
  cirno9_sim_monitor_if #(.XLEN(32), .CNT_W(32), .N_EVT(4)) ic ();
  cirno9_sim_monitor_if #(.XLEN(32), .CNT_W(4),  .N_EVT(2)) id ();

  cirno9_sim_monitor u_a (.clk(clk), .rst(rst), .bus(ia));
  cirno9_sim_monitor #(.HIT_MODE(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
  cirno9_sim_monitor #(.TIMEOUT_CYC(20)) u_c (.clk(clk), .rst(rst), .bus(ic));
  cirno9_sim_monitor #(.CNT_W(4), .N_EVT(2)) u_d (.clk(clk), .rst(rst), .bus(id));

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    ia.start = 0; ia.clear = 0; ia.pc = 0; ia.instr_retired = 0;
    ia.evt = 0; ia.result = 0;
    ib.start = 0; ib.clear = 0; ib.pc = 0; ib.instr_retired = 0;
    ib.evt = 0; ib.result = 0;
    ic.start = 0; ic.clear = 0; ic.pc = 0; ic.instr_retired = 0;
    ic.evt = 0; ic.result = 0;
    id.start = 0; id.clear = 0; id.pc = 0; id.instr_retired = 0;
    id.evt = 0; id.result = 0;
    tick(2);
    rst = 0;
    tick(1);

    check("rst_state", 64'(ia.state), 0);
    check("rst_cyc", 64'(ia.cycle_cnt), 0);
    check("rst_hit", 64'(ia.hit_cnt), 0);
    check("rst_done", 64'(ia.done), 0);
    check("rst_pf", 64'({ia.pass, ia.fail}), 0);
    check("rst_resq", 64'(ia.result_q), 0);

    // Default pass run
    ia.start = 1; tick(1);
    ia.start = 0;
    check("a_run", 64'(ia.state), 1);
    check("a_cyc0", 64'(ia.cycle_cnt), 0);
    ia.instr_retired = 1; tick(10);
    check("a_cyc10", 64'(ia.cycle_cnt), 10);
    ia.instr_retired = 0; ia.pc = M; ia.result = 1;
    tick(2);
    check("a_hit2", 64'(ia.hit_cnt), 2);
    check("a_notdone", 64'(ia.done), 0);
    tick(1);
    check("a_state", 64'(ia.state), 2);
    check("a_done", 64'(ia.done), 1);
    check("a_pass", 64'(ia.pass), 1);
    check("a_fail", 64'(ia.fail), 0);
    check("a_cyc", 64'(ia.cycle_cnt), 13);
    check("a_inst", 64'(ia.instret_cnt), 10);
    check("a_hit", 64'(ia.hit_cnt), 3);
    check("a_resq", 64'(ia.result_q), 1);
    ia.start = 1; ia.instr_retired = 1; ia.result = 9;
    tick(3);
    check("a_frz_cyc", 64'(ia.cycle_cnt), 13);
    check("a_frz_inst", 64'(ia.instret_cnt), 10);
    check("a_frz_state", 64'(ia.state), 2);
    check("a_frz_resq", 64'(ia.result_q), 1);

    // Fail verdict
    ia.start = 0; ia.instr_retired = 0; ia.pc = 0; ia.clear = 1;
    tick(1);
    ia.clear = 0;
    check("clr_state", 64'(ia.state), 0);
    check("clr_cyc", 64'(ia.cycle_cnt), 0);
    check("clr_pf", 64'({ia.pass, ia.fail}), 0);
    ia.start = 1; tick(1);
    ia.start = 0; ia.instr_retired = 1; tick(10);
    ia.instr_retired = 0; ia.pc = M; ia.result = 32'h5; tick(3);
    check("f_state", 64'(ia.state), 2);
    check("f_pass", 64'(ia.pass), 0);
    check("f_fail", 64'(ia.fail), 1);
    check("f_resq", 64'(ia.result_q), 5);

    // HIT_MODE=1 entries
    ib.start = 1; tick(1);
    ib.start = 0; ib.result = 1;
    ib.pc = M; tick(2);
    check("b_hit1", 64'(ib.hit_cnt), 1);
    ib.pc = 0; tick(2);
    ib.pc = M; tick(2);
    check("b_hit2", 64'(ib.hit_cnt), 2);
    check("b_run", 64'(ib.state), 1);
    ib.pc = 0; tick(2);
    ib.pc = M; tick(1);
    check("b_state", 64'(ib.state), 2);
    check("b_hit3", 64'(ib.hit_cnt), 3);
    check("b_cyc", 64'(ib.cycle_cnt), 9);
    check("b_pass", 64'(ib.pass), 1);
    ib.clear = 1; ib.pc = 0; tick(1);
    ib.clear = 0; ib.start = 1; tick(1);
    ib.start = 0; ib.pc = M; tick(5);
    check("b_hold_hit", 64'(ib.hit_cnt), 1);
    check("b_hold_st", 64'(ib.state), 1);

    // Timeout
    ic.start = 1; tick(1);
    ic.start = 0; ic.result = 7; tick(19);
    check("c_run19", 64'(ic.state), 1);
    check("c_cyc19", 64'(ic.cycle_cnt), 19);
    tick(1);
    check("c_state", 64'(ic.state), 3);
    check("c_cyc", 64'(ic.cycle_cnt), 20);
    check("c_done", 64'(ic.done), 1);
    check("c_fail", 64'(ic.fail), 1);
    check("c_pass", 64'(ic.pass), 0);
    check("c_resq", 64'(ic.result_q), 7);
    ic.instr_retired = 1; tick(3);
    check("c_frz_cyc", 64'(ic.cycle_cnt), 20);
    check("c_frz_inst", 64'(ic.instret_cnt), 0);
    ic.instr_retired = 0; ic.clear = 1; tick(1);
    ic.clear = 0; ic.start = 1; tick(1);
    ic.start = 0; ic.result = 1; tick(17);
    ic.pc = M; tick(3);
    check("tie_state", 64'(ic.state), 2);
    check("tie_pass", 64'(ic.pass), 1);
    check("tie_fail", 64'(ic.fail), 0);
    check("tie_cyc", 64'(ic.cycle_cnt), 20);

    // Saturation on narrow counters
    id.start = 1; tick(1);
    id.start = 0; id.evt = 2'b01; tick(20);
    check("d_evt0", 64'(id.evt_cnt[3:0]), 15);
    check("d_evt1", 64'(id.evt_cnt[7:4]), 0);
    check("d_cyc", 64'(id.cycle_cnt), 15);
    check("d_state", 64'(id.state), 1);

    // Control: events, clear+start, async reset
    ia.clear = 1; ia.pc = 0; tick(1);
    ia.clear = 0; ia.start = 1; tick(1);
    ia.start = 0; ia.evt = 4'b1010; tick(4);
    check("e_ch0", 64'(ia.evt_cnt[31:0]), 0);
    check("e_ch1", 64'(ia.evt_cnt[63:32]), 4);
    check("e_ch2", 64'(ia.evt_cnt[95:64]), 0);
    check("e_ch3", 64'(ia.evt_cnt[127:96]), 4);
    ia.evt = 0; ia.clear = 1; ia.start = 1; tick(1);
    ia.clear = 0; ia.start = 0;
    check("cs_state", 64'(ia.state), 0);
    check("cs_cyc", 64'(ia.cycle_cnt), 0);
    check("cs_evt", 64'(ia.evt_cnt[63:32]), 0);
    tick(2);
    check("cs_idle", 64'(ia.state), 0);
    ia.start = 1; tick(1);
    ia.start = 0; ia.instr_retired = 1; tick(5);
    check("r_pre", 64'(ia.cycle_cnt), 5);
    #3 rst = 1;
    #1;
    check("r_state", 64'(ia.state), 0);
    check("r_cyc", 64'(ia.cycle_cnt), 0);
    check("r_inst", 64'(ia.instret_cnt), 0);
    #2 rst = 0;
    tick(2);
    check("r_norun", 64'(ia.state), 0);
    ia.start = 1; tick(1);
    ia.start = 0; tick(3);
    check("r_cyc3", 64'(ia.cycle_cnt), 3);
    check("r_inst3", 64'(ia.instret_cnt), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
